// File: rtl/pipelined_lz_counter.sv
// Pipelined leading-zero / leading-one counter with elastic valid/ready stages.
// The operand rides along with its partial counts so data and shift amount leave together.
module pipelined_lz_counter #(
  parameter int DATA_WIDTH       = 32,
  parameter int LEVELS_PER_STAGE = 1,
  localparam int CNT_W = $clog2(DATA_WIDTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_mode,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_W-1:0]      out_count,
  output logic                  out_all,
  output logic                  out_mode
);
  localparam int LOG  = $clog2(DATA_WIDTH);
  localparam int LPS  = LEVELS_PER_STAGE;
  localparam int HALF = DATA_WIDTH / 2;
  localparam int NS   = (LOG + LPS - 1) / LPS;

  typedef logic [CNT_W-1:0] cnt_t;

  logic                  vld_q  [NS];
  cnt_t                  cnt_q  [NS][HALF];
  logic [DATA_WIDTH-1:0] data_q [NS];
  logic                  mode_q [NS];

  logic                  v_in [NS];
  logic [DATA_WIDTH-1:0] d_in [NS];
  logic                  m_in [NS];

  cnt_t                  lvl [LOG][HALF];
  cnt_t                  nxt [NS][HALF];
  logic [NS-1:0]         adv;
  logic [DATA_WIDTH-1:0] opnd;

  function automatic cnt_t enc2(input logic [1:0] p);
    if (p[1])      enc2 = cnt_t'(0);
    else if (p[0]) enc2 = cnt_t'(1);
    else           enc2 = cnt_t'(2);
  endfunction

  // An all-leading upper field is exactly 2^j, so OR-ing in the lower count adds it.
  function automatic cnt_t merge(input cnt_t up, input cnt_t lo,
                                 input int j);
    if (!up[j])      merge = up;
    else if (!lo[j]) merge = up | lo;
    else             merge = cnt_t'(1) << (j + 1);
  endfunction

  function automatic int src_stage(input int j);
    return (j >= LPS) ? (j / LPS) - 1 : 0;
  endfunction

  function automatic int last_lvl(input int s);
    return (((s + 1) * LPS < LOG) ? (s + 1) * LPS : LOG) - 1;
  endfunction

  always_comb begin
    opnd = in_mode ? ~in_data : in_data;
    for (int j = 0; j < LOG; j++) begin
      for (int i = 0; i < HALF; i++) begin
        lvl[j][i] = '0;
      end
    end
    for (int i = 0; i < HALF; i++) begin
      lvl[0][i] = enc2(opnd[2*i +: 2]);
    end
    for (int j = 1; j < LOG; j++) begin
      for (int i = 0; i < (HALF >> j); i++) begin
        if (j % LPS == 0)
          lvl[j][i] = merge(cnt_q[src_stage(j)][2*i+1],
                            cnt_q[src_stage(j)][2*i], j);
        else
          lvl[j][i] = merge(lvl[j-1][2*i+1], lvl[j-1][2*i], j);
      end
    end
    for (int s = 0; s < NS; s++) begin
      nxt[s] = lvl[last_lvl(s)];
    end
  end

  // A stage may load unless every stage from it to the output is full and stalled.
  always_comb begin : g_adv
    logic a;
    for (int s = 0; s < NS; s++) begin
      a = out_ready;
      for (int t = s; t < NS; t++) begin
        a = a | ~vld_q[t];
      end
      adv[s] = a;
    end
  end

  always_comb begin
    v_in[0] = in_valid;
    d_in[0] = in_data;
    m_in[0] = in_mode;
    for (int s = 1; s < NS; s++) begin
      v_in[s] = vld_q[s-1];
      d_in[s] = data_q[s-1];
      m_in[s] = mode_q[s-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NS; s++) begin
        vld_q[s]  <= 1'b0;
        data_q[s] <= '0;
        mode_q[s] <= 1'b0;
        for (int i = 0; i < HALF; i++) begin
          cnt_q[s][i] <= '0;
        end
      end
    end else begin
      for (int s = 0; s < NS; s++) begin
        if (adv[s]) begin
          vld_q[s]  <= v_in[s];
          data_q[s] <= d_in[s];
          mode_q[s] <= m_in[s];
          cnt_q[s]  <= nxt[s];
        end
      end
    end
  end

  assign in_ready  = adv[0];
  assign out_valid = vld_q[NS-1];
  assign out_data  = data_q[NS-1];
  assign out_mode  = mode_q[NS-1];
  assign out_count = cnt_q[NS-1][0];
  assign out_all   = out_count[CNT_W-1];

endmodule

// File: tb/tb_pipelined_lz_counter.sv
// Directed-vector and scoreboard bench for pipelined_lz_counter.
// Main instance is 32-bit / 1 level per stage; small instances cover other parameters.
module tb_pipelined_lz_counter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic        out_ready = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_ready, out_valid, out_all, out_mode;
  logic [31:0] out_data;
  logic [5:0]  out_count;

  always #5 clk = ~clk;

  pipelined_lz_counter #(.DATA_WIDTH(32), .LEVELS_PER_STAGE(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_mode(in_mode), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_count(out_count),
    .out_all(out_all), .out_mode(out_mode));

  logic        p_valid = 1'b0;
  logic        p_mode = 1'b0;
  logic [3:0]  d4 = '0;
  logic [15:0] d16 = '0;
  logic [63:0] d64 = '0;
  logic        r4, r16, r64, v4, v16, v64, a4, a16, a64, m4, m16, m64;
  logic [3:0]  o4;
  logic [15:0] o16;
  logic [63:0] o64;
  logic [2:0]  c4;
  logic [4:0]  c16;
  logic [6:0]  c64;

  pipelined_lz_counter #(.DATA_WIDTH(4), .LEVELS_PER_STAGE(1)) u4 (
    .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(r4),
    .in_data(d4), .in_mode(p_mode), .out_valid(v4), .out_ready(1'b1),
    .out_data(o4), .out_count(c4), .out_all(a4), .out_mode(m4));

  pipelined_lz_counter #(.DATA_WIDTH(16), .LEVELS_PER_STAGE(2)) u16 (
    .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(r16),
    .in_data(d16), .in_mode(p_mode), .out_valid(v16), .out_ready(1'b1),
    .out_data(o16), .out_count(c16), .out_all(a16), .out_mode(m16));

  pipelined_lz_counter #(.DATA_WIDTH(64), .LEVELS_PER_STAGE(6)) u64 (
    .clk(clk), .rst(rst), .in_valid(p_valid), .in_ready(r64),
    .in_data(d64), .in_mode(p_mode), .out_valid(v64), .out_ready(1'b1),
    .out_data(o64), .out_count(c64), .out_all(a64), .out_mode(m64));

  typedef struct {
    logic [31:0] d;
    logic        m;
  } beat_t;

  typedef struct {
    logic [31:0] d;
    logic        m;
    int          cnt;
    logic        all;
  } vec_t;

  beat_t q[$];
  int    n_chk = 0;
  int    n_fail = 0;
  int    cyc = 0;
  int    n_out = 0;
  int    first_out = -1;
  int    last_out = -1;
  bit    acc;

  function automatic int ref_lz(input logic [31:0] d, input logic m);
    int c;
    bit run;
    c = 0;
    run = 1'b1;
    for (int i = 31; i >= 0; i--) begin
      if (run && d[i] == m) c++;
      else run = 1'b0;
    end
    return c;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Called just after a negedge with inputs driven; ends at the next negedge.
  task automatic cycle();
    beat_t b;
    int    e;
    #1;
    acc = !rst && in_valid && in_ready;
    if (acc) q.push_back('{in_data, in_mode});
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("unexpected_beat", 64'(out_data), 64'hDEAD);
      end else begin
        b = q.pop_front();
        e = ref_lz(b.d, b.m);
        chk("beat", 64'({out_data, out_mode, out_count, out_all}),
            64'({b.d, b.m, 6'(e), (e == 32)}));
      end
      n_out++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    @(negedge clk);
    cyc++;
  endtask

  vec_t        tv[5];
  int          k, idx, sent, guard, e;
  logic [31:0] r, d;
  logic        m;
  int          lat4, lat16, lat64;

  initial begin
    tv[0] = '{32'h0001_0000, 1'b0, 15, 1'b0};
    tv[1] = '{32'h0000_0000, 1'b0, 32, 1'b1};
    tv[2] = '{32'h8000_0000, 1'b0, 0,  1'b0};
    tv[3] = '{32'hFFF0_0000, 1'b1, 12, 1'b0};
    tv[4] = '{32'hFFFF_FFFF, 1'b1, 32, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_count", 64'(out_count), 64'(0));
    chk("rst_out_all", 64'(out_all), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_out_mode", 64'(out_mode), 64'(0));
    chk("rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);

    // Single beats into an empty pipe: latency and values.
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = tv[i].d;
      in_mode  = tv[i].m;
      #1;
      chk("vec_accept", 64'(in_ready), 64'(1));
      @(negedge clk);
      in_valid = 1'b0;
      k = 1;
      #1;
      while (!out_valid && k < 20) begin
        @(negedge clk);
        #1;
        k++;
      end
      chk($sformatf("vec%0d_latency", i), 64'(k), 64'(5));
      chk($sformatf("vec%0d_count", i), 64'(out_count), 64'(tv[i].cnt));
      chk($sformatf("vec%0d_all", i), 64'(out_all), 64'(tv[i].all));
      chk($sformatf("vec%0d_data", i), 64'(out_data), 64'(tv[i].d));
      chk($sformatf("vec%0d_mode", i), 64'(out_mode), 64'(tv[i].m));
      @(negedge clk);
      #1;
      chk($sformatf("vec%0d_single", i), 64'(out_valid), 64'(0));
      @(negedge clk);
    end

    // Full-rate sweep of a walking one.
    q.delete();
    n_out = 0;
    first_out = -1;
    for (int b = 31; b >= 0; b--) begin
      in_valid = 1'b1;
      in_data  = 32'(1) << b;
      in_mode  = 1'b0;
      cycle();
    end
    in_valid = 1'b0;
    repeat (10) cycle();
    chk("sweep_beats", 64'(n_out), 64'(32));
    chk("sweep_no_bubble", 64'(last_out - first_out), 64'(31));
    chk("sweep_drained", 64'(q.size()), 64'(0));

    // Back-pressure: fill to depth, hold, then release.
    q.delete();
    n_out = 0;
    out_ready = 1'b0;
    idx = 0;
    repeat (10) begin
      in_valid = (idx < 8);
      in_data  = 32'hFFFF_FFFF >> (3 * idx);
      in_mode  = idx[0];
      cycle();
      if (acc) idx++;
    end
    chk("bp_accepted", 64'(idx), 64'(5));
    #1;
    chk("bp_in_ready", 64'(in_ready), 64'(0));
    for (int i = 0; i < 3; i++) begin
      e = ref_lz(q[0].d, q[0].m);
      chk("bp_hold", 64'({out_valid, out_count, out_data}),
          64'({1'b1, 6'(e), q[0].d}));
      cycle();
    end
    out_ready = 1'b1;
    guard = 0;
    while ((idx < 8 || q.size() > 0) && guard < 50) begin
      in_valid = (idx < 8);
      in_data  = 32'hFFFF_FFFF >> (3 * idx);
      in_mode  = idx[0];
      cycle();
      if (acc) idx++;
      guard++;
    end
    in_valid = 1'b0;
    chk("bp_delivered", 64'(n_out), 64'(8));
    chk("bp_drained", 64'(q.size()), 64'(0));

    // Random valid/ready with biased leading runs.
    q.delete();
    n_out = 0;
    sent = 0;
    guard = 0;
    while (sent < 10000 && guard < 60000) begin
      in_valid  = ($urandom % 4) != 0;
      r         = $urandom;
      m         = 1'($urandom % 2);
      d         = r >> ($urandom % 33);
      in_data   = m ? ~d : d;
      in_mode   = m;
      out_ready = ($urandom % 3) != 0;
      cycle();
      if (acc) sent++;
      guard++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while (q.size() > 0 && guard < 70000) begin
      cycle();
      guard++;
    end
    chk("rand_sent", 64'(sent), 64'(10000));
    chk("rand_drained", 64'(q.size()), 64'(0));
    chk("rand_delivered", 64'(n_out), 64'(10000));

    // Reset with three beats in flight.
    q.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 32'h0000_00FF << i;
      in_mode  = 1'b0;
      cycle();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    q.delete();
    #1;
    chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
    chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
    @(negedge clk);
    n_out = 0;
    repeat (8) cycle();
    chk("mid_rst_no_stale", 64'(n_out), 64'(0));
    in_valid = 1'b1;
    in_data  = 32'h0000_0F00;
    in_mode  = 1'b0;
    cycle();
    in_valid = 1'b0;
    repeat (8) cycle();
    chk("mid_rst_next_beat", 64'(n_out), 64'(1));

    // Other parameter sets: latency and count.
    for (int rnd = 0; rnd < 2; rnd++) begin
      p_valid = 1'b1;
      p_mode  = (rnd == 1);
      d4  = (rnd == 1) ? 4'h0 : 4'h1;
      d16 = (rnd == 1) ? 16'hFFFF : 16'h0F00;
      d64 = (rnd == 1) ? 64'hFFFF_0000_0000_0000 : 64'h1;
      if (rnd == 1) d4 = 4'hF;
      lat4 = 0;
      lat16 = 0;
      lat64 = 0;
      @(negedge clk);
      p_valid = 1'b0;
      for (int t = 1; t < 8; t++) begin
        #1;
        if (v4 && lat4 == 0) begin
          lat4 = t;
          chk("p4_count", 64'(c4), (rnd == 1) ? 64'(4) : 64'(3));
          chk("p4_all", 64'(a4), 64'(rnd == 1));
        end
        if (v16 && lat16 == 0) begin
          lat16 = t;
          chk("p16_count", 64'(c16), (rnd == 1) ? 64'(16) : 64'(4));
          chk("p16_all", 64'(a16), 64'(rnd == 1));
        end
        if (v64 && lat64 == 0) begin
          lat64 = t;
          chk("p64_count", 64'(c64), (rnd == 1) ? 64'(16) : 64'(63));
          chk("p64_all", 64'(a64), 64'(0));
        end
        @(negedge clk);
      end
      chk("p4_latency", 64'(lat4), 64'(2));
      chk("p16_latency", 64'(lat16), 64'(2));
      chk("p64_latency", 64'(lat64), 64'(1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipelined_lz_counter.md
Name: pipelined_lz_counter

Overview:
- Parametrised, pipelined leading-zero / leading-one counter for the EDP normalisation path.
- Builds the full count tree from 2-bit pair codes: 00 -> 2, 01 -> 1, 1x -> 0.
- Adds a valid/ready elastic pipeline, a per-transaction mode select and an all-zero flag.
- Carries the original operand alongside the count, so the downstream normalising shifter receives data and shift amount in the same beat.

Parameters:
- DATA_WIDTH, 32, operand width. Power of two, at least 4.
- LEVELS_PER_STAGE, 1, tree merge levels per register stage. Range 1..log2(DATA_WIDTH).
- CNT_W, $clog2(DATA_WIDTH)+1, count width (derived, not overridable).

Ports:
- clk  in  1  clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  block can accept an input beat this cycle.
- in_data  in  DATA_WIDTH  operand; bit DATA_WIDTH-1 is the MSB (leading end).
- in_mode  in  1  0 = count leading zeros, 1 = count leading ones.
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accepts a result beat.
- out_data  out  DATA_WIDTH  in_data of the same transaction, unmodified.
- out_count  out  CNT_W  number of leading zeros (mode 0) or leading ones (mode 1), 0..DATA_WIDTH.
- out_all  out  1  1 when out_count == DATA_WIDTH (operand is all zeros in mode 0, all ones in mode 1).
- out_mode  out  1  in_mode of the same transaction.

Behaviour:
- Mode 1 handling: the operand is bit-inverted before encoding; out_data is always the original, non-inverted operand.
- Tree structure:
  - Level 0 is the 2-bit pair encode.
  - Each merge level combines two adjacent k-bit counts into one (k+1)-bit count:
    - if the upper count's MSB is 0, the result is {0, upper};
    - else if the lower count's MSB is 0, the result is {01, lower[k-2:0]};
    - else (both sub-fields all-leading), the result is {1, 0...}.
  - log2(DATA_WIDTH)-1 merge levels produce the CNT_W-bit result.
- Registering: pair encode plus the first LEVELS_PER_STAGE-1 merges are combinational into stage 1. Each further group of LEVELS_PER_STAGE merges is followed by a register stage.
- Latency: L = ceil(log2(DATA_WIDTH)/LEVELS_PER_STAGE) cycles, from accepted input beat to out_valid. Example: DATA_WIDTH=32, LEVELS_PER_STAGE=1 gives L = 5.
- Per-stage storage: valid bit, partial counts, data and mode.
- Handshakes:
  - An input beat is accepted when in_valid && in_ready.
  - An output beat is consumed when out_valid && out_ready.
- Stall rules:
  - Stage s advances when it holds nothing, or when stage s+1 advances this cycle.
  - The last stage advances when !out_valid || out_ready.
  - in_ready = !stage1_valid || stage1 advances. This is a combinational path from out_ready through the stage chain, by design.
- Throughput:
  - One beat per cycle when out_ready is held high.
  - A bubble never blocks upstream.
  - With out_ready low, the pipeline fills to L beats and then deasserts in_ready.
- Output stability: while out_valid && !out_ready, out_data, out_count, out_all and out_mode hold stable.
- Ordering: results leave in acceptance order; none are lost or duplicated.
- Simultaneous events: with a full pipeline and out_ready high, one beat is consumed and one is accepted in the same cycle.
- Reset:
  - All stage valid bits clear. out_valid = 0, out_count = 0, out_all = 0, out_data = 0, out_mode = 0.
  - in_ready = 1 in the first cycle after reset is released.
  - Reset mid-operation discards all in-flight beats; no output beat appears for them.
- Input gating: inputs are ignored while rst is high.

Test Plan:
- Single-beat values, DATA_WIDTH=32, LEVELS_PER_STAGE=1, out_ready=1:
  - mode 0, in_data=0x0001_0000 -> out_count=15, out_all=0, out_valid exactly 5 cycles after acceptance.
  - mode 0, in_data=0x0000_0000 -> out_count=32, out_all=1.
  - mode 0, in_data=0x8000_0000 -> out_count=0.
  - mode 1, in_data=0xFFF0_0000 -> out_count=12, out_data=0xFFF0_0000.
  - mode 1, in_data=0xFFFF_FFFF -> out_count=32, out_all=1.
- Full-rate sweep: mode 0, in_data = 1<<k for k = 31 down to 0, one beat per cycle -> out_count = 31-k on consecutive cycles, no bubbles.
- Back-pressure: out_ready=0 while 8 beats are offered -> in_ready drops after 5 accepted beats. The held output stays stable. Release out_ready -> all 8 results delivered in order.
- Random stall: random in_valid/out_ready, 10k random operands and modes -> every out_count matches a reference model, order preserved.
- Reset mid-flight: assert rst for 1 cycle with 3 beats in flight -> out_valid=0 the next cycle, no stale beats delivered, next accepted beat correct.
- Parameter sweep: DATA_WIDTH in {4, 16, 64} with LEVELS_PER_STAGE in {1, 2, log2(DATA_WIDTH)} -> latency matches the formula. DATA_WIDTH=4, mode 0, in_data=0x1 -> out_count=3.
